df_qp_sched: RTL and testbench

DF_QP_SCHED -- requirements
Module: df_qp_sched

---
 rtl/df_qp_sched_pkg.sv | 41 ++++
 rtl/df_qp_sched_if.sv | 31 +++
 rtl/df_qp_line_ram.sv | 30 +++
 rtl/df_qp_sched.sv | 191 +++++++++++++++++++
 tb/tb_df_qp_sched.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/df_qp_sched_pkg.sv
// Shared definitions for the deblocking-filter QP scheduler.
// Optional feature macro: DF_QP_CHROMA_EN
//   defined   -> line RAM word is {QPc,QPy} (12 bits), chroma average computed
//   undefined -> line RAM word is QPy only (6 bits), chroma average forced to 0
package df_qp_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_WR,
        S_EDGE,
        S_DONE
    } state_t;

    localparam int unsigned QP_W      = 6;
    localparam int unsigned H_W       = 7;
    localparam int unsigned V_W       = 8;
    localparam int unsigned EDGE_W    = 3;

    localparam logic [EDGE_W-1:0] EDGE_V0   = 3'd0;
    localparam logic [EDGE_W-1:0] EDGE_H0   = 3'd4;
    localparam int unsigned       NUM_EDGES = 8;

    localparam int unsigned RAM_DEPTH = 128;
    localparam int unsigned RAM_AW    = 7;
`ifdef DF_QP_CHROMA_EN
    localparam int unsigned RAM_DW    = 2 * QP_W;
`else
    localparam int unsigned RAM_DW    = QP_W;
`endif

    // (P + Q + 1) >> 1 using a 7-bit sum, result truncated to 6 bits.
    function automatic logic [QP_W-1:0] qp_avg(input logic [QP_W-1:0] p,
                                               input logic [QP_W-1:0] q);
        logic [QP_W:0] sum;
        sum = {1'b0, p} + {1'b0, q} + 7'd1;
        return sum[QP_W:1];
    endfunction

endpackage

// File: rtl/df_qp_sched_if.sv
// Edge hand-off interface between the QP scheduler and the edge filter.
//   edge_valid : scheduler presents an edge
//   edge_ready : consumer accepts the current edge
//   edge_idx   : 0-3 vertical edges, 4-7 horizontal edges
//   qPav_y/c   : averaged luma/chroma QP for edge_idx
interface df_qp_sched_if;
    import df_qp_sched_pkg::*;

    logic                  edge_valid;
    logic                  edge_ready;
    logic [EDGE_W-1:0]     edge_idx;
    logic [QP_W-1:0]       qPav_y;
    logic [QP_W-1:0]       qPav_c;

    modport master (
        output edge_valid,
        output edge_idx,
        output qPav_y,
        output qPav_c,
        input  edge_ready
    );

    modport slave (
        input  edge_valid,
        input  edge_idx,
        input  qPav_y,
        input  qPav_c,
        output edge_ready
    );

endinterface

// File: rtl/df_qp_line_ram.sv
// Single-port synchronous line RAM holding the QP of the MB above each column.
//   clk   : clock
//   we    : write enable (write wins if ever asserted with re)
//   re    : read enable, data valid one cycle later on rdata
//   addr  : MB column
//   wdata : word to write
//   rdata : registered read data
// Contents are intentionally not reset.
module df_qp_line_ram
    import df_qp_sched_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [RAM_AW-1:0] addr,
    input  logic [RAM_DW-1:0] wdata,
    output logic [RAM_DW-1:0] rdata
);

    logic [RAM_DW-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/df_qp_sched.sv
// Deblocking-filter QP scheduler: per MB, fetches the top QP from the line
// RAM, stores the current QP for the next row, then emits the averaged QP for
// each of the 8 edges (skipping picture-boundary edges) over a valid/ready
// hand-off.
// Optional feature macro: DF_QP_CHROMA_EN (chroma QP tracking and averaging).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : end-of-decode pulse for one MB
//   QPy_in, QPc_in     : QP of the current MB
//   mb_num_h, mb_num_v : MB column / row
//   eif (master)       : edge_valid/edge_ready/edge_idx/qPav_y/qPav_c
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse after the last edge transfers
//   overrun            : one-cycle pulse when start arrives while busy
module df_qp_sched
    import df_qp_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [QP_W-1:0]   QPy_in,
    input  logic [QP_W-1:0]   QPc_in,
    input  logic [H_W-1:0]    mb_num_h,
    input  logic [V_W-1:0]    mb_num_v,
    df_qp_sched_if.master     eif,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_t              state;
    logic [QP_W-1:0]     cur_qpy, left_qpy, top_qpy;
    logic [H_W-1:0]      cur_h;
    logic [V_W-1:0]      cur_v;
    logic [EDGE_W-1:0]   edge_cnt;
    logic                edge_valid;
    logic [QP_W-1:0]     pav_y, pav_c;

    logic [EDGE_W-1:0]   first_idx, next_idx;
    logic [QP_W-1:0]     first_y, next_y, first_c, next_c;
    logic                last_edge;

    logic                ram_we, ram_re;
    logic [RAM_DW-1:0]   ram_wdata, ram_rdata;

`ifdef DF_QP_CHROMA_EN
    logic [QP_W-1:0]     cur_qpc, left_qpc, top_qpc;
`else
    logic                unused_qpc;
    assign unused_qpc = ^QPc_in;
`endif

    function automatic logic [QP_W-1:0] edge_qp(input logic [EDGE_W-1:0] idx,
                                                input logic [QP_W-1:0]   cur,
                                                input logic [QP_W-1:0]   left,
                                                input logic [QP_W-1:0]   top);
        if (idx == EDGE_V0) begin
            return qp_avg(left, cur);
        end else if (idx == EDGE_H0) begin
            return qp_avg(top, cur);
        end
        return cur;
    endfunction

    // Edge 0 is skipped in the leftmost column, edge 4 in the top row.
    always_comb begin
        first_idx = (cur_h == '0) ? (EDGE_V0 + 3'd1) : EDGE_V0;
        next_idx  = edge_cnt + 3'd1;
        if (next_idx == EDGE_H0 && cur_v == '0) begin
            next_idx = EDGE_H0 + 3'd1;
        end
        last_edge = (edge_cnt == 3'(NUM_EDGES - 1));
        first_y   = edge_qp(first_idx, cur_qpy, left_qpy, top_qpy);
        next_y    = edge_qp(next_idx,  cur_qpy, left_qpy, top_qpy);
`ifdef DF_QP_CHROMA_EN
        first_c   = edge_qp(first_idx, cur_qpc, left_qpc, top_qpc);
        next_c    = edge_qp(next_idx,  cur_qpc, left_qpc, top_qpc);
`else
        first_c   = '0;
        next_c    = '0;
`endif
    end

    // Read (RD) strictly precedes write (WR) at the same column, so the
    // latched top QP is always the previous row's value.
    assign ram_re = (state == S_RD);
    assign ram_we = (state == S_WR);
`ifdef DF_QP_CHROMA_EN
    assign ram_wdata = {cur_qpc, cur_qpy};
`else
    assign ram_wdata = cur_qpy;
`endif

    df_qp_line_ram u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (cur_h),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            edge_cnt   <= '0;
            edge_valid <= 1'b0;
            pav_y      <= '0;
            pav_c      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            cur_qpy    <= '0;
            left_qpy   <= '0;
            top_qpy    <= '0;
            cur_h      <= '0;
            cur_v      <= '0;
`ifdef DF_QP_CHROMA_EN
            cur_qpc    <= '0;
            left_qpc   <= '0;
            top_qpc    <= '0;
`endif
        end else begin
            done    <= 1'b0;
            overrun <= start && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_qpy <= QPy_in;
                        cur_h   <= mb_num_h;
                        cur_v   <= mb_num_v;
`ifdef DF_QP_CHROMA_EN
                        cur_qpc <= QPc_in;
`endif
                        busy    <= 1'b1;
                        state   <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    top_qpy <= ram_rdata[QP_W-1:0];
`ifdef DF_QP_CHROMA_EN
                    top_qpc <= ram_rdata[2*QP_W-1:QP_W];
`endif
                    state   <= S_WR;
                end
                S_WR: begin
                    edge_cnt   <= first_idx;
                    pav_y      <= first_y;
                    pav_c      <= first_c;
                    edge_valid <= 1'b1;
                    state      <= S_EDGE;
                end
                S_EDGE: begin
                    if (edge_valid && eif.edge_ready) begin
                        if (last_edge) begin
                            edge_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            edge_cnt <= next_idx;
                            pav_y    <= next_y;
                            pav_c    <= next_c;
                        end
                    end
                end
                S_DONE: begin
                    left_qpy <= cur_qpy;
`ifdef DF_QP_CHROMA_EN
                    left_qpc <= cur_qpc;
`endif
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    edge_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign eif.edge_valid = edge_valid;
    assign eif.edge_idx   = edge_cnt;
    assign eif.qPav_y     = pav_y;
    assign eif.qPav_c     = pav_c;

endmodule

// File: tb/tb_df_qp_sched.sv
// Directed self-checking bench for df_qp_sched.
// Cycle numbering: start is sampled at edge T; a value "at T+c" is the value
// observed at the falling edge just before edge T+c.
module tb_df_qp_sched;
    import df_qp_sched_pkg::*;

`ifdef DF_QP_CHROMA_EN
    localparam bit CH = 1'b1;
`else
    localparam bit CH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  QPy_in, QPc_in;
    logic [6:0]  mb_num_h;
    logic [7:0]  mb_num_v;
    logic        busy, done, overrun;

    df_qp_sched_if eif();

    df_qp_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .QPy_in   (QPy_in),
        .QPc_in   (QPc_in),
        .mb_num_h (mb_num_h),
        .mb_num_v (mb_num_v),
        .eif      (eif),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations from one MB run.
    int         obs_n;
    logic [2:0] obs_idx [16];
    logic [5:0] obs_y   [16];
    logic [5:0] obs_c   [16];
    int         first_valid_c, done_c, done_cnt, ov_cnt, hold_viol, busy_gap;
    int         ov_c [4];
    bit         timeout;

    // Drives one MB and records transfers; ov1/ov2 inject extra starts (0 = none).
    task automatic do_mb(input logic [5:0] qy, input logic [5:0] qc,
                         input logic [6:0] h, input logic [7:0] v,
                         input logic [3:0] rpat, input int ov1, input int ov2);
        logic       pv, prdy;
        logic [2:0] pidx;
        logic [5:0] py, pc;
        int         k, tail;
        obs_n = 0; first_valid_c = -1; done_c = -1; done_cnt = 0;
        ov_cnt = 0; hold_viol = 0; busy_gap = 0; timeout = 1'b0;
        @(negedge clk);
        start = 1'b1; QPy_in = qy; QPc_in = qc; mb_num_h = h; mb_num_v = v;
        eif.edge_ready = 1'b0;
        @(posedge clk);
        pv = 1'b0; prdy = 1'b0; pidx = '0; py = '0; pc = '0; k = 0; tail = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start    = (c == ov1) || (c == ov2);
            QPy_in   = 6'd5;
            QPc_in   = 6'd7;
            mb_num_h = 7'd99;
            mb_num_v = 8'd77;
            if (pv && !prdy) begin
                if (!(eif.edge_valid === 1'b1 && eif.edge_idx === pidx &&
                      eif.qPav_y === py && eif.qPav_c === pc))
                    hold_viol++;
            end
            if (overrun === 1'b1) begin
                if (ov_cnt < 4) ov_c[ov_cnt] = c;
                ov_cnt++;
            end
            if (done === 1'b1) begin
                if (done_cnt == 0) done_c = c;
                done_cnt++;
            end
            if (done_cnt == 0 && busy !== 1'b1) busy_gap++;
            if (eif.edge_valid === 1'b1 && first_valid_c < 0) first_valid_c = c;
            eif.edge_ready = (eif.edge_valid === 1'b1) ? rpat[k % 4] : 1'b0;
            if (eif.edge_valid === 1'b1) k++;
            if (eif.edge_valid === 1'b1 && eif.edge_ready) begin
                if (obs_n < 16) begin
                    obs_idx[obs_n] = eif.edge_idx;
                    obs_y[obs_n]   = eif.qPav_y;
                    obs_c[obs_n]   = eif.qPav_c;
                end
                obs_n++;
            end
            pv = eif.edge_valid; prdy = eif.edge_ready;
            pidx = eif.edge_idx; py = eif.qPav_y; pc = eif.qPav_c;
            if (done_cnt > 0) tail++;
            if (tail == 3) break;
        end
        start = 1'b0;
        eif.edge_ready = 1'b0;
        if (done_cnt == 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({eif.edge_valid, busy, done, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {eif.edge_valid, busy, done, overrun});
        end
        n_cmp++;
        if ({eif.edge_idx, eif.qPav_y, eif.qPav_c} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_data: idx=%0d y=%0d c=%0d want all 0", eif.edge_idx, eif.qPav_y, eif.qPav_c);
        end
    endtask

    task automatic test_first_mb();
        logic [2:0] ei[$];
        ei = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        do_mb(6'd30, 6'd30, 7'd0, 8'd0, 4'b1111, 0, 0);
        n_cmp++;
        if (timeout) begin n_fail++; $display("FAIL first_mb timeout: no done within budget"); end
        n_cmp++;
        if (first_valid_c !== 4) begin n_fail++; $display("FAIL first_mb latency: got T+%0d want T+4", first_valid_c); end
        n_cmp++;
        if (done_c !== 10 || done_cnt !== 1) begin
            n_fail++; $display("FAIL first_mb done: at T+%0d count %0d want T+10 count 1", done_c, done_cnt);
        end
        n_cmp++;
        if (busy_gap !== 0) begin n_fail++; $display("FAIL first_mb busy: %0d low cycles want 0", busy_gap); end
        n_cmp++;
        if (obs_n !== ei.size()) begin n_fail++; $display("FAIL first_mb count: got %0d want %0d", obs_n, ei.size()); end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== 6'd30 || obs_c[i] !== (CH ? 6'd30 : 6'd0)) begin
                n_fail++;
                $display("FAIL first_mb edge%0d: idx=%0d y=%0d c=%0d want idx=%0d y=30", i, obs_idx[i], obs_y[i], obs_c[i], ei[i]);
            end
        end
    endtask

    task automatic test_left_edge();
        logic [2:0] ei[$];
        logic [5:0] ey[$];
        ei = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        ey = '{6'd32, 6'd33, 6'd33, 6'd33, 6'd33, 6'd33, 6'd33};
        do_mb(6'd33, 6'd33, 7'd1, 8'd0, 4'b1111, 0, 0);
        n_cmp++;
        if (obs_n !== ei.size() || timeout) begin n_fail++; $display("FAIL left_edge count: got %0d want %0d", obs_n, ei.size()); end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== ey[i] || obs_c[i] !== (CH ? ey[i] : 6'd0)) begin
                n_fail++;
                $display("FAIL left_edge edge%0d: idx=%0d y=%0d c=%0d want idx=%0d y=%0d", i, obs_idx[i], obs_y[i], obs_c[i], ei[i], ey[i]);
            end
        end
    endtask

    task automatic test_top_edge();
        logic [2:0] ei[$];
        logic [5:0] ey[$];
        // Row 0, column 1: left = 33 -> edge 0 = 27; RAM[1] = 20.
        do_mb(6'd20, 6'd20, 7'd1, 8'd0, 4'b1111, 0, 0);
        n_cmp++;
        if (obs_n !== 7 || obs_idx[0] !== 3'd0 || obs_y[0] !== 6'd27) begin
            n_fail++; $display("FAIL top_row0: n=%0d idx=%0d y=%0d want n=7 idx=0 y=27", obs_n, obs_idx[0], obs_y[0]);
        end
        // Row 1, column 0: top = RAM[0] = 30 -> edge 4 = 28, edge 0 skipped.
        ei = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ey = '{6'd25, 6'd25, 6'd25, 6'd28, 6'd25, 6'd25, 6'd25};
        do_mb(6'd25, 6'd25, 7'd0, 8'd1, 4'b1111, 0, 0);
        n_cmp++;
        if (obs_n !== ei.size() || timeout) begin n_fail++; $display("FAIL top_row1h0 count: got %0d want %0d", obs_n, ei.size()); end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== ey[i] || obs_c[i] !== (CH ? ey[i] : 6'd0)) begin
                n_fail++;
                $display("FAIL top_row1h0 edge%0d: idx=%0d y=%0d want idx=%0d y=%0d", i, obs_idx[i], obs_y[i], ei[i], ey[i]);
            end
        end
        // Row 1, column 1: top = 20, left = 25 -> edge 0 = 25, edge 4 = 23.
        ei = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ey = '{6'd25, 6'd25, 6'd25, 6'd25, 6'd23, 6'd25, 6'd25, 6'd25};
        do_mb(6'd25, 6'd25, 7'd1, 8'd1, 4'b1111, 0, 0);
        n_cmp++;
        if (obs_n !== ei.size() || timeout) begin n_fail++; $display("FAIL top_row1h1 count: got %0d want %0d", obs_n, ei.size()); end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== ey[i] || obs_c[i] !== (CH ? ey[i] : 6'd0)) begin
                n_fail++;
                $display("FAIL top_row1h1 edge%0d: idx=%0d y=%0d want idx=%0d y=%0d", i, obs_idx[i], obs_y[i], ei[i], ey[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0] ei[$];
        logic [5:0] ey[$];
        // Row 1, column 0: top = RAM[0] = 25 -> edge 4 = 19. Ready 1,0,0,1.
        ei = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ey = '{6'd12, 6'd12, 6'd12, 6'd19, 6'd12, 6'd12, 6'd12};
        do_mb(6'd12, 6'd12, 7'd0, 8'd1, 4'b1001, 0, 0);
        n_cmp++;
        if (hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold: %0d changes during stall want 0", hold_viol); end
        n_cmp++;
        if (obs_n !== ei.size() || done_cnt !== 1) begin
            n_fail++; $display("FAIL stall_count: got %0d edges %0d done want %0d edges 1 done", obs_n, done_cnt, ei.size());
        end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== ey[i] || obs_c[i] !== (CH ? ey[i] : 6'd0)) begin
                n_fail++;
                $display("FAIL stall edge%0d: idx=%0d y=%0d want idx=%0d y=%0d", i, obs_idx[i], obs_y[i], ei[i], ey[i]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [2:0] ei[$];
        logic [5:0] ey[$];
        // left = 12 -> edge 0 = 26. Extra starts sampled at T+5 (EDGE) and T+11 (DONE).
        ei = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        ey = '{6'd26, 6'd40, 6'd40, 6'd40, 6'd40, 6'd40, 6'd40};
        do_mb(6'd40, 6'd40, 7'd1, 8'd0, 4'b1111, 5, 11);
        n_cmp++;
        if (ov_cnt !== 2 || ov_c[0] !== 6 || ov_c[1] !== 12) begin
            n_fail++; $display("FAIL overrun_pulse: count %0d at %0d,%0d want 2 at 6,12", ov_cnt, ov_c[0], ov_c[1]);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_c !== 11) begin
            n_fail++; $display("FAIL overrun_done: count %0d at %0d want 1 at 11", done_cnt, done_c);
        end
        n_cmp++;
        if (obs_n !== ei.size()) begin n_fail++; $display("FAIL overrun_count: got %0d want %0d", obs_n, ei.size()); end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== ey[i]) begin
                n_fail++;
                $display("FAIL overrun edge%0d: idx=%0d y=%0d want idx=%0d y=%0d", i, obs_idx[i], obs_y[i], ei[i], ey[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || eif.edge_valid !== 1'b0) begin
            n_fail++; $display("FAIL overrun_idle: busy=%b valid=%b want 0 0", busy, eif.edge_valid);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        logic [2:0] ei[$];
        logic [5:0] ey[$];
        logic [5:0] ec[$];
        @(negedge clk);
        start = 1'b1; QPy_in = 6'd50; QPc_in = 6'd50; mb_num_h = 7'd1; mb_num_v = 8'd0;
        eif.edge_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 5; c++) @(negedge clk);
        n_cmp++;
        if (eif.edge_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: valid=%b want 1", eif.edge_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({eif.edge_valid, busy, done} !== 3'b000 || eif.edge_idx !== 3'd0 || eif.qPav_y !== 6'd0) begin
            n_fail++;
            $display("FAIL rmid_post: valid=%b busy=%b done=%b idx=%0d y=%0d want 0", eif.edge_valid, busy, done, eif.edge_idx, eif.qPav_y);
        end
        reset = 1'b0;
        eif.edge_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (eif.edge_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        eif.edge_ready = 1'b0;
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL rmid_quiet: %0d active cycles want 0", bad); end
        // Left QP cleared: (0 + 51 + 1) >> 1 = 26; chroma (0 + 9 + 1) >> 1 = 5.
        ei = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        ey = '{6'd26, 6'd51, 6'd51, 6'd51, 6'd51, 6'd51, 6'd51};
        ec = '{6'd5, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9};
        do_mb(6'd51, 6'd9, 7'd1, 8'd0, 4'b1111, 0, 0);
        n_cmp++;
        if (obs_n !== ei.size() || timeout) begin n_fail++; $display("FAIL rmid_next count: got %0d want %0d", obs_n, ei.size()); end
        for (int i = 0; i < ei.size() && i < obs_n; i++) begin
            n_cmp++;
            if (obs_idx[i] !== ei[i] || obs_y[i] !== ey[i] || obs_c[i] !== (CH ? ec[i] : 6'd0)) begin
                n_fail++;
                $display("FAIL rmid_next edge%0d: idx=%0d y=%0d c=%0d want idx=%0d y=%0d", i, obs_idx[i], obs_y[i], obs_c[i], ei[i], ey[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; QPy_in = '0; QPc_in = '0;
        mb_num_h = '0; mb_num_v = '0; eif.edge_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_first_mb();
        test_left_edge();
        test_top_edge();
        test_stall();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
